load_store_unit: RTL and testbench

//  Memory-side partner of the RV32I decoder. Consumes its mem-write request, load size and load-unsigned controls.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and store-formatting helpers for the load/store unit.
// Size codes match the decoder's load_size field.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    WAIT_RD = 2'b10
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    is_misaligned = (size == SZ_ILL) ||
                    ((size == SZ_HALF) && lo[0]) ||
                    ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: store_mask = MASK_BYTE << lo;
      SZ_HALF: store_mask = MASK_HALF << lo;
      default: store_mask = MASK_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      SZ_BYTE: store_wdata = {4{rs2[7:0]}};
      SZ_HALF: store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/half lane of a read word down to bit 0 and
// sign- or zero-extends it for writeback.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_in,
  input  logic [1:0]  addr_lo_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  output logic [31:0] data_out
);

  logic [31:0] shifted;
  logic        fill_byte;
  logic        fill_half;

  always_comb begin
    shifted   = rdata_in >> {addr_lo_in, 3'b000};
    fill_byte = ~unsigned_in & shifted[7];
    fill_half = ~unsigned_in & shifted[15];
    case (size_in)
      SZ_BYTE: data_out = {{24{fill_byte}}, shifted[7:0]};
      SZ_HALF: data_out = {{16{fill_half}}, shifted[15:0]};
      default: data_out = rdata_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory master for RV32I loads and stores.
// Captures a request in IDLE, runs the bus handshake and pulses a completion flag.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        mem_wr_req_in,
  input  logic        mem_rd_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] rs2_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_mask_out,
  input  logic        dmem_ready_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        store_done_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        stall_out
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        req_q, req_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        store_done_q, store_done_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] aligned_data;

  lsu_load_align u_align (
    .rdata_in    (dmem_rdata_in),
    .addr_lo_in  (addr_q[1:0]),
    .size_in     (size_q),
    .unsigned_in (uns_q),
    .data_out    (aligned_data)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    req_d        = req_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    store_done_d = 1'b0;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous rd/wr is treated as a store.
        if (mem_rd_req_in || mem_wr_req_in) begin
          addr_d  = addr_in;
          size_d  = load_size_in;
          uns_d   = load_unsigned_in;
          we_d    = mem_wr_req_in;
          wdata_d = store_wdata(load_size_in, rs2_in);
          mask_d  = store_mask(load_size_in, addr_in[1:0]);
          timer_d = '0;
          if (is_misaligned(load_size_in, addr_in[1:0])) begin
            misaligned_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (dmem_ready_in) begin
          req_d   = 1'b0;
          timer_d = '0;
          if (we_q) begin
            state_d      = IDLE;
            store_done_d = 1'b1;
          end else begin
            state_d = WAIT_RD;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid_in) begin
          state_d      = IDLE;
          load_data_d  = aligned_data;
          load_valid_d = 1'b1;
          timer_d      = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mask_q       <= '0;
      req_q        <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      req_q        <= req_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      store_done_q <= store_done_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dmem_req_out   = req_q;
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = {addr_q[31:2], 2'b00};
  assign dmem_wdata_out = wdata_q;
  assign dmem_mask_out  = mask_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign store_done_out = store_done_q;
  assign misaligned_out = misaligned_q;
  assign bus_err_out    = bus_err_q;
  assign stall_out      = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, signed/unsigned loads,
// misalignment, bus back-pressure, timeout abort and mid-transaction reset.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        rstN;
  logic        memWrReq, memRdReq;
  logic [1:0]  loadSize;
  logic        loadUnsigned;
  logic [31:0] addr, rs2;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic [3:0]  dmemMask;
  logic        dmemReady, dmemRvalid;
  logic [31:0] dmemRdata;
  logic [31:0] loadData;
  logic        loadValid, storeDone, misaligned, busErr, stall;

  int totalChecks = 0;
  int badChecks   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in           (clock),
    .rst_n_in         (rstN),
    .mem_wr_req_in    (memWrReq),
    .mem_rd_req_in    (memRdReq),
    .load_size_in     (loadSize),
    .load_unsigned_in (loadUnsigned),
    .addr_in          (addr),
    .rs2_in           (rs2),
    .dmem_req_out     (dmemReq),
    .dmem_we_out      (dmemWe),
    .dmem_addr_out    (dmemAddr),
    .dmem_wdata_out   (dmemWdata),
    .dmem_mask_out    (dmemMask),
    .dmem_ready_in    (dmemReady),
    .dmem_rvalid_in   (dmemRvalid),
    .dmem_rdata_in    (dmemRdata),
    .load_data_out    (loadData),
    .load_valid_out   (loadValid),
    .store_done_out   (storeDone),
    .misaligned_out   (misaligned),
    .bus_err_out      (busErr),
    .stall_out        (stall)
  );

  always #5 clock = ~clock;

  // Single comparison point so every check is counted the same way.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven and outputs sampled.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request for a single cycle; the DUT captures it on the next edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] size,
                               input logic uns, input logic [31:0] a, input logic [31:0] d);
    memWrReq     = wr;
    memRdReq     = rd;
    loadSize     = size;
    loadUnsigned = uns;
    addr         = a;
    rs2          = d;
    step();
    memWrReq = 1'b0;
    memRdReq = 1'b0;
  endtask

  // Load with immediate ready and rvalid one cycle after ready; checks the result pulse.
  task automatic doLoad(input string tag, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] rdata, input logic [31:0] expData);
    dmemReady = 1'b1;
    applyStimulus(1'b0, 1'b1, size, uns, a, 32'h0);
    checkOutput({tag, "_req"}, {31'b0, dmemReq}, 32'd1);
    step();
    checkOutput({tag, "_waitReq"}, {31'b0, dmemReq}, 32'd0);
    dmemRvalid = 1'b1;
    dmemRdata  = rdata;
    step();
    dmemRvalid = 1'b0;
    dmemRdata  = 32'h0;
    checkOutput({tag, "_valid"}, {31'b0, loadValid}, 32'd1);
    checkOutput({tag, "_data"}, loadData, expData);
    step();
    checkOutput({tag, "_validLow"}, {31'b0, loadValid}, 32'd0);
    checkOutput({tag, "_hold"}, loadData, expData);
  endtask

  initial begin
    rstN = 1'b0;
    memWrReq = 1'b0; memRdReq = 1'b0; loadSize = 2'b00; loadUnsigned = 1'b0;
    addr = 32'h0; rs2 = 32'h0; dmemReady = 1'b0; dmemRvalid = 1'b0; dmemRdata = 32'h0;
    step();
    step();
    checkOutput("rst_req", {31'b0, dmemReq}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_loadData", loadData, 32'h0);
    checkOutput("rst_mask", {28'b0, dmemMask}, 32'h0);
    rstN = 1'b1;
    step();

    // SB with immediate ready
    dmemReady = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    checkOutput("sb_req", {31'b0, dmemReq}, 32'd1);
    checkOutput("sb_we", {31'b0, dmemWe}, 32'd1);
    checkOutput("sb_addr", dmemAddr, 32'h0000_1000);
    checkOutput("sb_mask", {28'b0, dmemMask}, 32'h8);
    checkOutput("sb_wdata", dmemWdata, 32'hA5A5_A5A5);
    checkOutput("sb_stall", {31'b0, stall}, 32'd1);
    step();
    checkOutput("sb_done", {31'b0, storeDone}, 32'd1);
    checkOutput("sb_stallLow", {31'b0, stall}, 32'd0);
    checkOutput("sb_reqLow", {31'b0, dmemReq}, 32'd0);
    step();
    checkOutput("sb_doneLow", {31'b0, storeDone}, 32'd0);

    // rd and wr together: SH wins
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'h1234_BEEF);
    checkOutput("sh_we", {31'b0, dmemWe}, 32'd1);
    checkOutput("sh_mask", {28'b0, dmemMask}, 32'hC);
    checkOutput("sh_wdata", dmemWdata, 32'hBEEF_BEEF);
    step();
    checkOutput("sh_done", {31'b0, storeDone}, 32'd1);
    step();

    doLoad("lb", 2'b00, 1'b0, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
    doLoad("lbu", 2'b00, 1'b1, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
    doLoad("lh", 2'b01, 1'b0, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
    doLoad("lhu", 2'b01, 1'b1, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);

    // Misaligned LW and illegal size
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_2001, 32'h0);
    checkOutput("lwMis_pulse", {31'b0, misaligned}, 32'd1);
    checkOutput("lwMis_req", {31'b0, dmemReq}, 32'd0);
    checkOutput("lwMis_stall", {31'b0, stall}, 32'd0);
    step();
    checkOutput("lwMis_pulseLow", {31'b0, misaligned}, 32'd0);
    checkOutput("lwMis_reqLow", {31'b0, dmemReq}, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_2000, 32'h0);
    checkOutput("ill_pulse", {31'b0, misaligned}, 32'd1);
    checkOutput("ill_req", {31'b0, dmemReq}, 32'd0);
    step();

    // SW with ready held low for 5 cycles
    dmemReady = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      checkOutput("swBp_req", {31'b0, dmemReq}, 32'd1);
      checkOutput("swBp_addr", dmemAddr, 32'h0000_3000);
      checkOutput("swBp_wdata", dmemWdata, 32'h1234_5678);
      checkOutput("swBp_mask", {28'b0, dmemMask}, 32'hF);
      checkOutput("swBp_stall", {31'b0, stall}, 32'd1);
      checkOutput("swBp_doneLow", {31'b0, storeDone}, 32'd0);
      step();
    end
    dmemReady = 1'b1;
    step();
    checkOutput("swBp_done", {31'b0, storeDone}, 32'd1);
    checkOutput("swBp_stallLow", {31'b0, stall}, 32'd0);
    step();

    // LW with rvalid never arriving: abort after 8 WAIT_RD cycles
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
    step();
    for (int i = 0; i < 7; i++) begin
      checkOutput("to_stall", {31'b0, stall}, 32'd1);
      checkOutput("to_errLow", {31'b0, busErr}, 32'd0);
      step();
    end
    checkOutput("to_stallLast", {31'b0, stall}, 32'd1);
    step();
    checkOutput("to_err", {31'b0, busErr}, 32'd1);
    checkOutput("to_stallLow", {31'b0, stall}, 32'd0);
    checkOutput("to_reqLow", {31'b0, dmemReq}, 32'd0);
    checkOutput("to_validLow", {31'b0, loadValid}, 32'd0);
    step();
    checkOutput("to_errPulse", {31'b0, busErr}, 32'd0);

    // Reset during WAIT_RD, then a normal load
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    step();
    checkOutput("rstMid_stall", {31'b0, stall}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rstMid_stallLow", {31'b0, stall}, 32'd0);
    checkOutput("rstMid_req", {31'b0, dmemReq}, 32'd0);
    checkOutput("rstMid_data", loadData, 32'h0);
    checkOutput("rstMid_valid", {31'b0, loadValid}, 32'd0);
    checkOutput("rstMid_err", {31'b0, busErr}, 32'd0);
    step();
    rstN = 1'b1;
    step();
    doLoad("lwPost", 2'b10, 1'b0, 32'h0000_5004, 32'hCAFE_BABE, 32'hCAFE_BABE);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
